// File: rtl/pimsynth_pkg.sv
// Shared types for the PIM synthesis benchmark blocks.
// Holds the uint8 operand types and the shift request record.
package pimsynth_pkg;

    localparam int UINT8_W       = 8;
    localparam int UINT8_SHAMT_W = 3;

    typedef logic [UINT8_W-1:0] uint8_t;

    typedef struct packed {
        uint8_t a;
        uint8_t b;
    } shr_req_t;

endpackage

// File: rtl/shift_r_uint8.sv
// Combinational 8-bit unsigned right-shift core.
// Only the low shift-amount bits are seen here; out-of-range shifts are handled by the caller.
module shift_r_uint8
    import pimsynth_pkg::*;
(
    input  uint8_t                   a,
    input  logic [UINT8_SHAMT_W-1:0] shamt,
    output uint8_t                   y
);

    assign y = a >> shamt;

endmodule

// File: rtl/shift_r_uint8_stream.sv
// Streaming wrapper around shift_r_uint8: operand FIFO, shift core, registered output stage.
// Shifts of WIDTH or more return 0 and raise out_ovf alongside the result.
module shift_r_uint8_stream
    import pimsynth_pkg::*;
#(
    parameter int WIDTH       = UINT8_W,
    parameter int SHIFT_WIDTH = UINT8_SHAMT_W,
    parameter int DEPTH       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    shr_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    shr_req_t         head;
    logic             fifo_nonempty;
    logic             push;
    logic             pop;
    logic             head_ovf;
    uint8_t           core_y;

    // in_ready depends on registered occupancy only, so a full FIFO never
    // accepts in the same cycle it pops.
    assign in_ready      = (occupancy < DEPTH_OCC);
    assign fifo_nonempty = (occupancy != '0);
    assign push          = in_valid && in_ready;
    assign pop           = fifo_nonempty && (!out_valid || out_ready);

    assign head     = mem[rd_ptr];
    assign head_ovf = |head.b[WIDTH-1:SHIFT_WIDTH];

    shift_r_uint8 u_core (
        .a     (head.a),
        .shamt (head.b[SHIFT_WIDTH-1:0]),
        .y     (core_y)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_ovf   <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_y     <= head_ovf ? '0 : core_y;
            out_ovf   <= head_ovf;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
